// File: rtl/mcs_io_responder.sv
// mcs_io_responder: registered responder between the MicroBlaze MCS I/O bus and
// the FPro MMIO subsystem.
//
// Requests are accepted only in IDLE.
// An in-window access goes through three stages. It issues a one-cycle
// ACCESS strobe, then stretches through WAIT while the slot holds fp_wait,
// then returns a one-cycle RESP with the registered read data.
// An out-of-window access goes straight to RESP with zero data and touches no
// FPro signal.
//
// Optional feature, enabled by defining MCS_IO_RESP_TIMEOUT_EN. It adds a
// WAIT-cycle watchdog: after TIMEOUT stalled WAIT cycles the access is
// abandoned, reads return ERR_DATA, and err_cnt counts the event, saturating
// at 255. Without the macro, WAIT lasts until the slot releases fp_wait and
// err_cnt is tied to 0.

`timescale 1ns / 1ps

module mcs_io_responder #(
  parameter logic [31:0] BRG_BASE = 32'hC000_0000,
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        reset_n,
  // MCS I/O bus
  input  logic        io_addr_strobe,
  input  logic        io_read_strobe,
  input  logic        io_write_strobe,
  input  logic [3:0]  io_byte_enable,
  input  logic [31:0] io_address,
  input  logic [31:0] io_write_data,
  output logic [31:0] io_read_data,
  output logic        io_ready,
  // FPro MMIO side
  output logic        fp_mmio_cs,
  output logic        fp_wr,
  output logic        fp_rd,
  output logic [20:0] fp_addr,
  output logic [31:0] fp_wr_data,
  output logic [3:0]  fp_byte_en,
  input  logic [31:0] fp_rd_data,
  input  logic        fp_wait,
  // Status
  output logic [7:0]  err_cnt
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StAccess = 2'd1;
  localparam logic [1:0] StWait   = 2'd2;
  localparam logic [1:0] StResp   = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [20:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        rd_q, rd_d;
  logic [31:0] rdata_q, rdata_d;

  logic req;
  logic in_window;
  logic timeout_hit;

  // Byte offset bits never reach the word-addressed FPro bus.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^io_address[1:0];

  assign req       = io_addr_strobe & (io_read_strobe | io_write_strobe);
  assign in_window = (io_address[31:23] == BRG_BASE[31:23]);

`ifdef MCS_IO_RESP_TIMEOUT_EN
  // Counter holds the number of completed WAIT cycles, so the TIMEOUT-th
  // stalled WAIT cycle is the one where it equals TIMEOUT-1.
  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT - 1);

  logic [15:0] wcnt_q, wcnt_d;
  logic [7:0]  err_q, err_d;

  // A falling fp_wait always wins over the watchdog in the same cycle.
  assign timeout_hit = (state_q == StWait) && fp_wait && (wcnt_q == TimeoutLast);

  // Watchdog counter and saturating timeout count.
  always_comb begin
    wcnt_d = wcnt_q;
    err_d  = err_q;
    if (state_q == StAccess && fp_wait) begin
      wcnt_d = '0;
    end else if (state_q == StWait) begin
      wcnt_d = wcnt_q + 16'd1;
    end
    if (timeout_hit && (err_q != 8'hFF)) begin
      err_d = err_q + 8'd1;
    end
  end

  // Watchdog state registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wcnt_q <= '0;
      err_q  <= '0;
    end else begin
      wcnt_q <= wcnt_d;
      err_q  <= err_d;
    end
  end

  assign err_cnt = err_q;
`else
  assign timeout_hit = 1'b0;
  assign err_cnt     = 8'h00;
`endif

  // Transaction FSM and request latching.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rd_d    = rd_q;
    rdata_d = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          addr_d  = io_address[22:2];
          wdata_d = io_write_data;
          be_d    = io_byte_enable;
          rd_d    = io_read_strobe;  // read wins when both strobes are high
          rdata_d = '0;              // out-of-window and write responses carry 0
          state_d = in_window ? StAccess : StResp;
        end
      end
      StAccess: begin
        if (!fp_wait) begin
          if (rd_q) begin
            rdata_d = fp_rd_data;
          end
          state_d = StResp;
        end else begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (!fp_wait) begin
          if (rd_q) begin
            rdata_d = fp_rd_data;
          end
          state_d = StResp;
        end else if (timeout_hit) begin
          rdata_d = rd_q ? ERR_DATA : 32'h0;
          state_d = StResp;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Main state registers; reset clears everything so all outputs read 0.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rd_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rd_q    <= rd_d;
      rdata_q <= rdata_d;
    end
  end

  // Output decode: FPro signals live only in ACCESS/WAIT, CPU response only in RESP.
  always_comb begin
    logic active;
    active       = (state_q == StAccess) || (state_q == StWait);
    fp_mmio_cs   = active;
    fp_rd        = (state_q == StAccess) && rd_q;
    fp_wr        = (state_q == StAccess) && !rd_q;
    fp_addr      = active ? addr_q : 21'h0;
    fp_wr_data   = active ? wdata_q : 32'h0;
    fp_byte_en   = active ? be_q : 4'h0;
    io_ready     = (state_q == StResp);
    io_read_data = (state_q == StResp) ? rdata_q : 32'h0;
  end

endmodule

// File: tb/tb_mcs_io_responder.sv
// Directed bench for mcs_io_responder. Built with or without
// MCS_IO_RESP_TIMEOUT_EN; the timeout scenario runs only when it is defined.

`timescale 1ns / 1ps

module tb_mcs_io_responder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        io_addr_strobe, io_read_strobe, io_write_strobe;
  logic [3:0]  io_byte_enable;
  logic [31:0] io_address, io_write_data, io_read_data;
  logic        io_ready;
  logic        fp_mmio_cs, fp_wr, fp_rd;
  logic [20:0] fp_addr;
  logic [31:0] fp_wr_data;
  logic [3:0]  fp_byte_en;
  logic [31:0] fp_rd_data;
  logic        fp_wait;
  logic [7:0]  err_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mcs_io_responder #(
    .BRG_BASE(32'hC000_0000),
    .TIMEOUT (8),
    .ERR_DATA(32'hDEAD_BEEF)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .io_addr_strobe (io_addr_strobe),
    .io_read_strobe (io_read_strobe),
    .io_write_strobe(io_write_strobe),
    .io_byte_enable (io_byte_enable),
    .io_address     (io_address),
    .io_write_data  (io_write_data),
    .io_read_data   (io_read_data),
    .io_ready       (io_ready),
    .fp_mmio_cs     (fp_mmio_cs),
    .fp_wr          (fp_wr),
    .fp_rd          (fp_rd),
    .fp_addr        (fp_addr),
    .fp_wr_data     (fp_wr_data),
    .fp_byte_en     (fp_byte_en),
    .fp_rd_data     (fp_rd_data),
    .fp_wait        (fp_wait),
    .err_cnt        (err_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    io_addr_strobe  = 1'b0;
    io_read_strobe  = 1'b0;
    io_write_strobe = 1'b0;
  endtask

  task automatic start_req(input logic rd, input logic wr, input logic [31:0] a,
                           input logic [31:0] wd, input logic [3:0] be);
    io_addr_strobe  = 1'b1;
    io_read_strobe  = rd;
    io_write_strobe = wr;
    io_address      = a;
    io_write_data   = wd;
    io_byte_enable  = be;
  endtask

  // Issue one request in cycle 0, hold fp_wait for cycles 1..nw, present rdata in
  // cycle nw+1 (junk otherwise), and observe cycles 1..ncyc.
  task automatic run_access(input logic rd, input logic wr, input logic [31:0] a,
                            input logic [31:0] wd, input logic [3:0] be, input int nw,
                            input logic [31:0] rdata, input int ncyc,
                            output int rdy_at, output logic [31:0] rdy_data,
                            output logic [7:0] rdy_err, output int cs_n, output int rd_n,
                            output int wr_n);
    rdy_at = -1; rdy_data = 'x; rdy_err = 'x; cs_n = 0; rd_n = 0; wr_n = 0;
    start_req(rd, wr, a, wd, be);
    fp_wait = 1'b0;
    step();
    for (int c = 1; c <= ncyc; c++) begin
      idle_inputs();
      fp_wait    = (c <= nw);
      fp_rd_data = (c == nw + 1) ? rdata : 32'h1111_1111;
      #1;
      if (fp_mmio_cs) cs_n++;
      if (fp_rd) rd_n++;
      if (fp_wr) wr_n++;
      if (io_ready) begin
        rdy_at   = c;
        rdy_data = io_read_data;
        rdy_err  = err_cnt;
      end
      step();
    end
    fp_wait = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    io_address = '0; io_write_data = '0; io_byte_enable = '0;
    fp_rd_data = '0; fp_wait = 1'b0;
    reset_n = 1'b0;
    step();
    step();
    n_cmp++;
    if ({io_ready, io_read_data, fp_mmio_cs, fp_rd, fp_wr, fp_addr, fp_wr_data, fp_byte_en,
         err_cnt} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: ready=%b rdata=%h cs=%b rd=%b wr=%b addr=%h err=%0d, want all 0",
               io_ready, io_read_data, fp_mmio_cs, fp_rd, fp_wr, fp_addr, err_cnt);
    end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_read_zero_wait();
    start_req(1'b1, 1'b0, 32'hC000_0010, 32'h0, 4'hF);
    fp_rd_data = 32'h1234_5678;
    fp_wait    = 1'b0;
    #1;
    n_cmp++;
    if (fp_mmio_cs !== 1'b0 || io_ready !== 1'b0) begin
      n_err++;
      $display("FAIL rd_cycle0: cs=%b ready=%b, want 0 0", fp_mmio_cs, io_ready);
    end
    step();
    idle_inputs();
    n_cmp++;
    if ({fp_mmio_cs, fp_rd, fp_wr, io_ready} !== 4'b1100 || fp_addr !== 21'd4) begin
      n_err++;
      $display("FAIL rd_cycle1: cs/rd/wr/ready=%b%b%b%b addr=%0d, want 1100 addr=4",
               fp_mmio_cs, fp_rd, fp_wr, io_ready, fp_addr);
    end
    step();
    fp_rd_data = 32'h0BAD_0BAD;  // response must come from the captured value
    #1;
    n_cmp++;
    if (io_ready !== 1'b1 || io_read_data !== 32'h1234_5678 || fp_mmio_cs !== 1'b0) begin
      n_err++;
      $display("FAIL rd_cycle2: ready=%b data=%h cs=%b, want 1 12345678 0",
               io_ready, io_read_data, fp_mmio_cs);
    end
    step();
    n_cmp++;
    if (io_ready !== 1'b0 || io_read_data !== 32'h0) begin
      n_err++;
      $display("FAIL rd_cycle3: ready=%b data=%h, want 0 00000000", io_ready, io_read_data);
    end
  endtask

  task automatic test_write();
    start_req(1'b0, 1'b1, 32'hC000_0100, 32'hA5A5_0001, 4'b0011);
    fp_rd_data = 32'hFFFF_FFFF;
    step();
    idle_inputs();
    n_cmp++;
    if ({fp_mmio_cs, fp_wr, fp_rd} !== 3'b110 || fp_addr !== 21'd64 ||
        fp_byte_en !== 4'b0011 || fp_wr_data !== 32'hA5A5_0001) begin
      n_err++;
      $display("FAIL wr_cycle1: cs/wr/rd=%b%b%b addr=%0d be=%b wdata=%h, want 110 64 0011 a5a50001",
               fp_mmio_cs, fp_wr, fp_rd, fp_addr, fp_byte_en, fp_wr_data);
    end
    step();
    n_cmp++;
    if (io_ready !== 1'b1 || io_read_data !== 32'h0 || fp_wr_data !== 32'h0 ||
        fp_byte_en !== 4'h0) begin
      n_err++;
      $display("FAIL wr_cycle2: ready=%b data=%h wdata=%h be=%b, want 1 0 0 0",
               io_ready, io_read_data, fp_wr_data, fp_byte_en);
    end
    step();
  endtask

  task automatic test_wait();
    int rdy_at, cs_n, rd_n, wr_n;
    logic [31:0] d;
    logic [7:0] e;
    run_access(1'b1, 1'b0, 32'hC000_0020, 32'h0, 4'hF, 5, 32'hCAFE_F00D, 9,
               rdy_at, d, e, cs_n, rd_n, wr_n);
    n_cmp++;
    if (cs_n !== 6 || rd_n !== 1 || wr_n !== 0) begin
      n_err++;
      $display("FAIL wait5_strobes: cs=%0d rd=%0d wr=%0d cycles, want 6 1 0", cs_n, rd_n, wr_n);
    end
    n_cmp++;
    if (rdy_at !== 7 || d !== 32'hCAFE_F00D) begin
      n_err++;
      $display("FAIL wait5_resp: ready cycle=%0d data=%h, want 7 cafef00d", rdy_at, d);
    end
  endtask

  task automatic test_out_of_window();
    start_req(1'b1, 1'b0, 32'h8000_0000, 32'h0, 4'hF);
    fp_rd_data = 32'hFFFF_FFFF;
    step();
    idle_inputs();
    n_cmp++;
    if (io_ready !== 1'b1 || io_read_data !== 32'h0 || fp_mmio_cs !== 1'b0 || fp_rd !== 1'b0) begin
      n_err++;
      $display("FAIL oow_cycle1: ready=%b data=%h cs=%b rd=%b, want 1 0 0 0",
               io_ready, io_read_data, fp_mmio_cs, fp_rd);
    end
    step();
    n_cmp++;
    if (io_ready !== 1'b0 || fp_mmio_cs !== 1'b0) begin
      n_err++;
      $display("FAIL oow_cycle2: ready=%b cs=%b, want 0 0", io_ready, fp_mmio_cs);
    end
  endtask

  // Strobes held high with both directions asserted: read wins, re-accepted every 3 cycles.
  task automatic test_back_to_back();
    logic [6:1] rd_seen, wr_seen, rdy_seen;
    logic [31:0] d2;
    rd_seen = '0; wr_seen = '0; rdy_seen = '0; d2 = '0;
    start_req(1'b1, 1'b1, 32'hC000_0040, 32'h0, 4'hF);
    fp_rd_data = 32'h0BAD_0001;
    fp_wait    = 1'b0;
    step();
    for (int c = 1; c <= 6; c++) begin
      if (c == 6) idle_inputs();
      #1;
      rd_seen[c]  = fp_rd;
      wr_seen[c]  = fp_wr;
      rdy_seen[c] = io_ready;
      if (c == 5) d2 = io_read_data;
      step();
    end
    n_cmp++;
    if (rd_seen !== 6'b001001 || wr_seen !== 6'b000000) begin
      n_err++;
      $display("FAIL b2b_strobes: rd=%b wr=%b, want 001001 000000", rd_seen, wr_seen);
    end
    n_cmp++;
    if (rdy_seen !== 6'b010010 || d2 !== 32'h0BAD_0001) begin
      n_err++;
      $display("FAIL b2b_ready: ready=%b data=%h, want 010010 0bad0001", rdy_seen, d2);
    end
    n_cmp++;
    if (fp_mmio_cs !== 1'b0 || io_ready !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_idle: cs=%b ready=%b, want 0 0", fp_mmio_cs, io_ready);
    end
  endtask

`ifdef MCS_IO_RESP_TIMEOUT_EN
  task automatic test_timeout();
    int rdy_at, cs_n, rd_n, wr_n;
    logic [31:0] d;
    logic [7:0] e;
    // Stuck read: ACCESS in cycle 1, WAIT cycles 2..9, RESP in cycle 10.
    run_access(1'b1, 1'b0, 32'hC000_0004, 32'h0, 4'hF, 1000, 32'h0, 11,
               rdy_at, d, e, cs_n, rd_n, wr_n);
    n_cmp++;
    if (rdy_at !== 10 || d !== 32'hDEAD_BEEF || e !== 8'd1 || cs_n !== 9) begin
      n_err++;
      $display("FAIL to_read: ready cycle=%0d data=%h err=%0d cs=%0d, want 10 deadbeef 1 9",
               rdy_at, d, e, cs_n);
    end
    run_access(1'b0, 1'b1, 32'hC000_0008, 32'h1, 4'hF, 1000, 32'h0, 11,
               rdy_at, d, e, cs_n, rd_n, wr_n);
    n_cmp++;
    if (rdy_at !== 10 || d !== 32'h0 || e !== 8'd2) begin
      n_err++;
      $display("FAIL to_write: ready cycle=%0d data=%h err=%0d, want 10 0 2", rdy_at, d, e);
    end
    // fp_wait falls in the cycle the watchdog would fire: normal completion.
    run_access(1'b1, 1'b0, 32'hC000_000C, 32'h0, 4'hF, 8, 32'h7777_0000, 11,
               rdy_at, d, e, cs_n, rd_n, wr_n);
    n_cmp++;
    if (rdy_at !== 10 || d !== 32'h7777_0000 || e !== 8'd2) begin
      n_err++;
      $display("FAIL to_boundary: ready cycle=%0d data=%h err=%0d, want 10 77770000 2",
               rdy_at, d, e);
    end
    for (int i = 0; i < 298; i++) begin
      run_access(1'b1, 1'b0, 32'hC000_0004, 32'h0, 4'hF, 1000, 32'h0, 10,
                 rdy_at, d, e, cs_n, rd_n, wr_n);
    end
    n_cmp++;
    if (err_cnt !== 8'd255) begin
      n_err++;
      $display("FAIL to_saturate: err_cnt=%0d, want 255", err_cnt);
    end
  endtask
`else
  task automatic test_long_wait();
    int rdy_at, cs_n, rd_n, wr_n;
    logic [31:0] d;
    logic [7:0] e;
    run_access(1'b1, 1'b0, 32'hC000_0000, 32'h0, 4'hF, 20, 32'h5555_AAAA, 23,
               rdy_at, d, e, cs_n, rd_n, wr_n);
    n_cmp++;
    if (rdy_at !== 22 || d !== 32'h5555_AAAA || cs_n !== 21 || e !== 8'd0) begin
      n_err++;
      $display("FAIL long_wait: ready cycle=%0d data=%h cs=%0d err=%0d, want 22 5555aaaa 21 0",
               rdy_at, d, cs_n, e);
    end
  endtask
`endif

  task automatic test_reset_mid();
    logic any_ready;
    int rdy_at, cs_n, rd_n, wr_n;
    logic [31:0] d;
    logic [7:0] e;
    start_req(1'b1, 1'b0, 32'hC000_0030, 32'h0, 4'hF);
    fp_wait = 1'b1;
    step();  // cycle 1: ACCESS
    idle_inputs();
    step();  // cycle 2: WAIT
    reset_n = 1'b0;
    step();
    n_cmp++;
    if ({io_ready, io_read_data, fp_mmio_cs, fp_rd, fp_wr, fp_addr, fp_wr_data, fp_byte_en,
         err_cnt} !== '0) begin
      n_err++;
      $display("FAIL rst_mid_outputs: ready=%b cs=%b addr=%h err=%0d, want all 0",
               io_ready, fp_mmio_cs, fp_addr, err_cnt);
    end
    step();
    reset_n = 1'b1;
    fp_wait = 1'b0;
    any_ready = io_ready | fp_mmio_cs;
    step();
    any_ready |= io_ready;
    step();
    any_ready |= io_ready;
    n_cmp++;
    if (any_ready !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid_no_ready: saw ready/cs=%b, want 0", any_ready);
    end
    run_access(1'b1, 1'b0, 32'hC000_0008, 32'h0, 4'hF, 0, 32'h0246_8ACE, 3,
               rdy_at, d, e, cs_n, rd_n, wr_n);
    n_cmp++;
    if (rdy_at !== 2 || d !== 32'h0246_8ACE || rd_n !== 1) begin
      n_err++;
      $display("FAIL rst_mid_new_read: ready cycle=%0d data=%h rd=%0d, want 2 02468ace 1",
               rdy_at, d, rd_n);
    end
  endtask

  initial begin
    test_reset();
    test_read_zero_wait();
    test_write();
    test_wait();
    test_out_of_window();
    test_back_to_back();
`ifdef MCS_IO_RESP_TIMEOUT_EN
    test_timeout();
`else
    test_long_wait();
`endif
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
